// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: splits 32-bit loads/stores into two 16-bit async SRAM phases.
// Optional SRAM_POSTED_WRITE_EN: stores are buffered and retire with zero freeze cycles.
module mem_stage_sram_ctrl #(
    parameter int unsigned SRAM_WAIT = 1,
    parameter int unsigned SRAM_BASE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_res,
    input  logic [31:0] val_Rm,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        last;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [15:0] dq_out;

    assign last = (cnt == 3'(SRAM_WAIT));
    assign word = 17'((alu_res - 32'(SRAM_BASE)) >> 2);

`ifdef SRAM_POSTED_WRITE_EN
    // Store payload captured at acceptance; the pipeline has moved on by the drain.
    logic [31:0] wbuf;
    assign wdata = wbuf;
`else
    assign wdata = val_Rm;
`endif

    always_comb begin
        dq_out = wdata[15:0];
        if (state == WR_HI) dq_out = wdata[31:16];
    end

    assign sram_dq = (state == WR_LO || state == WR_HI) ? dq_out : 16'bz;

    always_comb begin
        ready = 1'b0;
        case (state)
`ifdef SRAM_POSTED_WRITE_EN
            IDLE:         ready = mem_w_en | ~mem_r_en;
            WR_LO, WR_HI: ready = ~(mem_r_en | mem_w_en);
`else
            IDLE:         ready = ~(mem_r_en | mem_w_en);
`endif
            DONE:         ready = 1'b1;
            default:      ready = 1'b0;
        endcase
    end

    // Sequencer; the write strobe rises on each phase's last cycle to give data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            rdata     <= 32'd0;
            sram_addr <= 18'd0;
            sram_we_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (mem_w_en) begin
                        state     <= WR_LO;
                        sram_addr <= {word, 1'b0};
                        sram_we_n <= 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
                        wbuf      <= val_Rm;
`endif
                    end else if (mem_r_en) begin
                        state     <= RD_LO;
                        sram_addr <= {word, 1'b0};
                    end
                end
                RD_LO, RD_HI, WR_LO, WR_HI: begin
                    if (!last) begin
                        cnt <= cnt + 3'd1;
                        if (state == WR_LO || state == WR_HI)
                            sram_we_n <= ((cnt + 3'd1) == 3'(SRAM_WAIT));
                    end else begin
                        cnt <= 3'd0;
                        case (state)
                            RD_LO: begin
                                rdata[15:0]  <= sram_dq;
                                sram_addr[0] <= 1'b1;
                                state        <= RD_HI;
                            end
                            RD_HI: begin
                                rdata[31:16] <= sram_dq;
                                state        <= DONE;
                            end
                            WR_LO: begin
                                sram_addr[0] <= 1'b1;
                                sram_we_n    <= 1'b0;
                                state        <= WR_HI;
                            end
                            default: begin
                                sram_we_n <= 1'b1;
`ifdef SRAM_POSTED_WRITE_EN
                                state     <= IDLE;
`else
                                state     <= DONE;
`endif
                            end
                        endcase
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: W=1 instance (a_*) and W=0 instance (b_*),
// each with a small async SRAM model.
module tb_mem_stage_sram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---- instance A: SRAM_WAIT = 1 ----
    logic        a_r, a_w, a_ready, a_we_n, a_oe;
    logic [31:0] a_addr, a_wd, a_rdata;
    logic [17:0] a_saddr;
    logic [15:0] a_rd;
    wire  [15:0] a_dq;
    logic [15:0] a_mem [0:63];

    // ---- instance B: SRAM_WAIT = 0 ----
    logic        b_r, b_w, b_ready, b_we_n, b_oe;
    logic [31:0] b_addr, b_wd, b_rdata;
    logic [17:0] b_saddr;
    logic [15:0] b_rd;
    wire  [15:0] b_dq;
    logic [15:0] b_mem [0:63];

    mem_stage_sram_ctrl #(.SRAM_WAIT(1), .SRAM_BASE(1024)) u_dut_a (
        .clk(clk), .rst(rst), .mem_r_en(a_r), .mem_w_en(a_w),
        .alu_res(a_addr), .val_Rm(a_wd), .rdata(a_rdata), .ready(a_ready),
        .sram_addr(a_saddr), .sram_dq(a_dq), .sram_we_n(a_we_n)
    );

    mem_stage_sram_ctrl #(.SRAM_WAIT(0), .SRAM_BASE(1024)) u_dut_b (
        .clk(clk), .rst(rst), .mem_r_en(b_r), .mem_w_en(b_w),
        .alu_res(b_addr), .val_Rm(b_wd), .rdata(b_rdata), .ready(b_ready),
        .sram_addr(b_saddr), .sram_dq(b_dq), .sram_we_n(b_we_n)
    );

    // Read contents are fixed per address; writes land in a separate capture array.
    assign a_rd = (a_saddr == 18'd0) ? 16'hBEEF : (a_saddr == 18'd1) ? 16'hDEAD : 16'h0000;
    assign b_rd = (b_saddr == 18'd0) ? 16'h1111 : (b_saddr == 18'd1) ? 16'h2222 : 16'h0000;
    assign a_dq = a_oe ? a_rd : 16'bz;
    assign b_dq = b_oe ? b_rd : 16'bz;

    always @(posedge clk) begin
        if (!a_we_n) a_mem[a_saddr[5:0]] <= a_dq;
        if (!b_we_n) b_mem[b_saddr[5:0]] <= b_dq;
    end

    task test_reset;
        rst = 1'b1;
        a_r = 0; a_w = 0; a_addr = 0; a_wd = 0; a_oe = 0;
        b_r = 0; b_w = 0; b_addr = 0; b_wd = 0; b_oe = 0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (a_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_a_rdata got %h exp 0", a_rdata); end
        vectors++; if (a_saddr !== 18'd0) begin miscompares++; $display("FAIL rst_a_saddr got %h exp 0", a_saddr); end
        vectors++; if (a_we_n !== 1'b1) begin miscompares++; $display("FAIL rst_a_we_n got %b exp 1", a_we_n); end
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL rst_a_ready got %b exp 1", a_ready); end
        vectors++; if (b_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_b_rdata got %h exp 0", b_rdata); end
        vectors++; if (b_we_n !== 1'b1) begin miscompares++; $display("FAIL rst_b_we_n got %b exp 1", b_we_n); end
        vectors++; if (b_ready !== 1'b1) begin miscompares++; $display("FAIL rst_b_ready got %b exp 1", b_ready); end
        rst = 1'b0;
    endtask

    task test_read;
        @(negedge clk);
        a_oe = 1; a_r = 1; a_addr = 32'd1024;
        #1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            vectors++;
            if (a_ready !== 1'(c == 5)) begin miscompares++; $display("FAIL rd_ready c%0d got %b exp %b", c, a_ready, (c == 5)); end
            if (c >= 1 && c <= 4) begin
                vectors++;
                if (a_saddr !== ((c <= 2) ? 18'd0 : 18'd1)) begin miscompares++; $display("FAIL rd_saddr c%0d got %h", c, a_saddr); end
            end
        end
        vectors++; if (a_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_rdata got %h exp deadbeef", a_rdata); end
        a_r = 0; a_oe = 0;
    endtask

    task test_write;
        logic [15:0] exp_dq;
        @(negedge clk);
        a_w = 1; a_addr = 32'd1032; a_wd = 32'h12345678;
        #1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            vectors++;
            if (a_ready !== 1'(c == 5)) begin miscompares++; $display("FAIL wr_ready c%0d got %b exp %b", c, a_ready, (c == 5)); end
            if (c >= 1 && c <= 4) begin
                exp_dq = (c <= 2) ? 16'h5678 : 16'h1234;
                vectors++; if (a_we_n !== 1'(c % 2 == 0)) begin miscompares++; $display("FAIL wr_we_n c%0d got %b", c, a_we_n); end
                vectors++; if (a_dq !== exp_dq) begin miscompares++; $display("FAIL wr_dq c%0d got %h exp %h", c, a_dq, exp_dq); end
                vectors++; if (a_saddr !== ((c <= 2) ? 18'd4 : 18'd5)) begin miscompares++; $display("FAIL wr_saddr c%0d got %h", c, a_saddr); end
            end
        end
        vectors++; if (a_mem[4] !== 16'h5678) begin miscompares++; $display("FAIL wr_mem4 got %h exp 5678", a_mem[4]); end
        vectors++; if (a_mem[5] !== 16'h1234) begin miscompares++; $display("FAIL wr_mem5 got %h exp 1234", a_mem[5]); end
        a_w = 0;
    endtask

    task test_both_enables;
        @(negedge clk);
        a_r = 1; a_w = 1; a_addr = 32'd1040; a_wd = 32'hAAAA5555;
        #1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            vectors++;
            if (a_ready !== 1'(c == 5)) begin miscompares++; $display("FAIL both_ready c%0d got %b", c, a_ready); end
            if (c == 1) begin
                vectors++; if (a_we_n !== 1'b0) begin miscompares++; $display("FAIL both_we_n c1 got %b exp 0", a_we_n); end
            end
        end
        vectors++; if (a_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL both_rdata got %h exp deadbeef", a_rdata); end
        vectors++; if (a_mem[8] !== 16'h5555) begin miscompares++; $display("FAIL both_mem8 got %h exp 5555", a_mem[8]); end
        vectors++; if (a_mem[9] !== 16'hAAAA) begin miscompares++; $display("FAIL both_mem9 got %h exp aaaa", a_mem[9]); end
        a_r = 0; a_w = 0;
    endtask

    task test_reset_mid_read;
        @(negedge clk);
        a_oe = 1; a_r = 1; a_addr = 32'd1028;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        vectors++; if (a_rdata !== 32'd0) begin miscompares++; $display("FAIL rmr_rdata got %h exp 0", a_rdata); end
        vectors++; if (a_we_n !== 1'b1) begin miscompares++; $display("FAIL rmr_we_n got %b exp 1", a_we_n); end
        vectors++; if (a_saddr !== 18'd0) begin miscompares++; $display("FAIL rmr_saddr got %h exp 0", a_saddr); end
        vectors++; if (a_dq !== 16'hBEEF) begin miscompares++; $display("FAIL rmr_dq_released got %h exp beef", a_dq); end
        vectors++; if (a_ready !== 1'b0) begin miscompares++; $display("FAIL rmr_ready_req got %b exp 0", a_ready); end
        rst = 1'b0; a_r = 0; a_oe = 0;
        #1;
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL rmr_ready_idle got %b exp 1", a_ready); end
        @(negedge clk); #1;
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL rmr_ready_after got %b exp 1", a_ready); end
    endtask

    task test_back_to_back;
        logic [7:0] exp_ready;
        logic [7:0] exp_we_n;
        exp_ready = 8'b1000_1000;   // bit c = expected ready in cycle c
        exp_we_n  = 8'b1001_1111;   // strobe low in cycles 5 and 6
        @(negedge clk);
        b_oe = 1; b_r = 1; b_addr = 32'd1024;
        #1;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            vectors++;
            if (b_ready !== exp_ready[c]) begin miscompares++; $display("FAIL b2b_ready c%0d got %b exp %b", c, b_ready, exp_ready[c]); end
            vectors++;
            if (b_we_n !== exp_we_n[c]) begin miscompares++; $display("FAIL b2b_we_n c%0d got %b exp %b", c, b_we_n, exp_we_n[c]); end
            if (c == 3) begin
                vectors++; if (b_rdata !== 32'h22221111) begin miscompares++; $display("FAIL b2b_rdata got %h exp 22221111", b_rdata); end
                b_oe = 0; b_r = 0; b_w = 1; b_addr = 32'd1028; b_wd = 32'hCAFEF00D;
                #1;
            end
        end
        vectors++; if (b_mem[2] !== 16'hF00D) begin miscompares++; $display("FAIL b2b_mem2 got %h exp f00d", b_mem[2]); end
        vectors++; if (b_mem[3] !== 16'hCAFE) begin miscompares++; $display("FAIL b2b_mem3 got %h exp cafe", b_mem[3]); end
        b_w = 0;
    endtask

    task test_posted_write;
        @(negedge clk);
        a_oe = 0; a_w = 1; a_addr = 32'd1048; a_wd = 32'h0BADF00D;
        #1;
        vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL pw_ready c0 got %b exp 1", a_ready); end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin a_w = 0; a_r = 1; a_addr = 32'd1024; a_wd = 32'hFFFFFFFF; end
            if (c == 5) a_oe = 1;
            #1;
            vectors++;
            if (a_ready !== 1'(c == 10)) begin miscompares++; $display("FAIL pw_ready c%0d got %b exp %b", c, a_ready, (c == 10)); end
            if (c == 1 || c == 3) begin
                vectors++; if (a_dq !== ((c == 1) ? 16'hF00D : 16'h0BAD)) begin miscompares++; $display("FAIL pw_dq c%0d got %h", c, a_dq); end
                vectors++; if (a_saddr !== ((c == 1) ? 18'd12 : 18'd13)) begin miscompares++; $display("FAIL pw_saddr c%0d got %h", c, a_saddr); end
                vectors++; if (a_we_n !== 1'b0) begin miscompares++; $display("FAIL pw_we_n c%0d got %b exp 0", c, a_we_n); end
            end
        end
        vectors++; if (a_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL pw_rdata got %h exp deadbeef", a_rdata); end
        vectors++; if (a_mem[12] !== 16'hF00D) begin miscompares++; $display("FAIL pw_mem12 got %h exp f00d", a_mem[12]); end
        vectors++; if (a_mem[13] !== 16'h0BAD) begin miscompares++; $display("FAIL pw_mem13 got %h exp 0bad", a_mem[13]); end
        a_r = 0; a_oe = 0;
    endtask

    initial begin
        test_reset();
        test_read();
`ifndef SRAM_POSTED_WRITE_EN
        test_write();
        test_both_enables();
`endif
        test_reset_mid_read();
`ifndef SRAM_POSTED_WRITE_EN
        test_back_to_back();
`else
        test_posted_write();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
